// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage multiply/divide unit request and response bundle
interface mdu_ctrl_if;
  logic [3:0]  E_MDUop;
  logic [31:0] E_MDU_opA;
  logic [31:0] E_MDU_opB;
  logic        E_MDU_flush;
  logic        E_MDU_busy;
  logic        E_MDU_stall;
  logic [31:0] E_MDU_result;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master(output E_MDUop, E_MDU_opA, E_MDU_opB, E_MDU_flush,
                 input E_MDU_busy, E_MDU_stall, E_MDU_result, HI, LO);
  modport slave(input E_MDUop, E_MDU_opA, E_MDU_opB, E_MDU_flush,
                output E_MDU_busy, E_MDU_stall, E_MDU_result, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency mult/div sequencer owning HI/LO with stall and flush gating
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave m
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0] op;
  logic start, idle, sgn, mul;
  logic [63:0] prod;
  logic [31:0] ua, ub, uq, ur, q, r;
  assign op    = m.E_MDUop > 4'd8 ? 4'd0 : m.E_MDUop;
  assign idle  = state_q == IDLE;
  assign start = idle && op >= 4'd1 && op <= 4'd4 && !m.E_MDU_flush;
  assign sgn   = op_q == 4'd3;
  assign mul   = op_q <= 4'd2;
  // signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0
  always_comb begin
    prod = op_q == 4'd1 ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q} : {32'd0, a_q} * {32'd0, b_q};
    ua   = (sgn && a_q[31]) ? -a_q : a_q;
    ub   = (sgn && b_q[31]) ? -b_q : b_q;
    uq   = ub == 32'd0 ? 32'd0 : ua / ub;
    ur   = ub == 32'd0 ? 32'd0 : ua % ub;
    q    = (sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    r    = (sgn && a_q[31]) ? -ur : ur;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (start) begin
      state_d = BUSY;
      op_d    = op;
      a_d     = m.E_MDU_opA;
      b_d     = m.E_MDU_opB;
      cnt_d   = op <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (idle && !m.E_MDU_flush) begin
      hi_d = op == 4'd5 ? m.E_MDU_opA : hi_q;
      lo_d = op == 4'd6 ? m.E_MDU_opA : lo_q;
    end
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        hi_d = mul ? prod[63:32] : (ub != 32'd0 ? r : hi_q);
        lo_d = mul ? prod[31:0]  : (ub != 32'd0 ? q : lo_q);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign m.E_MDU_busy   = state_q == BUSY;
  assign m.E_MDU_stall  = op >= 4'd1 && (state_q == BUSY || start);
  assign m.E_MDU_result = op == 4'd7 ? hi_q : op == 4'd8 ? lo_q : 32'd0;
  assign m.HI = hi_q;
  assign m.LO = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed scenario tests for mdu_ctrl with hand-computed results
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  mdu_ctrl_if bus();
  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_MDUop = op;
    bus.E_MDU_opA = a;
    bus.E_MDU_opB = b;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (bus.E_MDU_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout got %0d cycles want <40", n);
    end
  endtask
  task automatic test_reset;
    drive(4'd0, 32'd0, 32'd0);
    bus.E_MDU_flush = 1'b0;
    #1;
    checks++; if (bus.E_MDU_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.E_MDU_busy); end
    checks++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.HI, bus.LO); end
    checks++; if (bus.E_MDU_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.E_MDU_stall); end
    tick();
    reset = 1'b1;
    tick();
  endtask
  task automatic test_mult;
    int n;
    drive(4'd1, 32'hFFFFFFFE, 32'd3);
    #1;
    checks++; if (bus.E_MDU_stall !== 1'b1 || bus.E_MDU_busy !== 1'b0) begin errors++; $display("FAIL mult_start got stall=%b busy=%b want 1/0", bus.E_MDU_stall, bus.E_MDU_busy); end
    tick();
    drive(4'd0, 32'd0, 32'd0);
    #1;
    checks++; if (bus.E_MDU_busy !== 1'b1 || bus.E_MDU_stall !== 1'b0) begin errors++; $display("FAIL mult_busy_nostall got busy=%b stall=%b want 1/0", bus.E_MDU_busy, bus.E_MDU_stall); end
    wait_done(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_latency got %0d want 5", n); end
    checks++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_result got %h/%h want ffffffff/fffffffa", bus.HI, bus.LO); end
    drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    wait_done(n);
    checks++; if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin errors++; $display("FAIL multu_result got %h/%h want fffffffe/00000001", bus.HI, bus.LO); end
  endtask
  task automatic test_div;
    int n;
    drive(4'd3, 32'hFFFFFFF9, 32'd2);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    wait_done(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_latency got %0d want 10", n); end
    checks++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", bus.HI, bus.LO); end
    drive(4'd4, 32'd7, 32'd0);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    wait_done(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_latency got %0d want 10", n); end
    checks++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL divz_unchanged got %h/%h want ffffffff/fffffffd", bus.HI, bus.LO); end
    drive(4'd4, 32'd100, 32'd7);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    wait_done(n);
    checks++; if (bus.HI !== 32'd2 || bus.LO !== 32'd14) begin errors++; $display("FAIL divu_result got %h/%h want 00000002/0000000e", bus.HI, bus.LO); end
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    wait_done(n);
    checks++; if (bus.HI !== 32'd0 || bus.LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h/%h want 00000000/80000000", bus.HI, bus.LO); end
  endtask
  task automatic test_flush;
    int n;
    drive(4'd3, 32'd9, 32'd2);
    bus.E_MDU_flush = 1'b1;
    #1;
    checks++; if (bus.E_MDU_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", bus.E_MDU_stall); end
    tick();
    drive(4'd0, 32'd0, 32'd0);
    bus.E_MDU_flush = 1'b0;
    #1;
    checks++; if (bus.E_MDU_busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'h80000000) begin errors++; $display("FAIL flush_div got busy=%b %h/%h want 0 00000000/80000000", bus.E_MDU_busy, bus.HI, bus.LO); end
    drive(4'd6, 32'h1234, 32'd0);
    bus.E_MDU_flush = 1'b1;
    tick();
    drive(4'd0, 32'd0, 32'd0);
    bus.E_MDU_flush = 1'b0;
    #1;
    checks++; if (bus.LO !== 32'h80000000) begin errors++; $display("FAIL flush_mtlo got %h want 80000000", bus.LO); end
    drive(4'd1, 32'd3, 32'd4);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    bus.E_MDU_flush = 1'b1;
    wait_done(n);
    bus.E_MDU_flush = 1'b0;
    checks++; if (n != 5 || bus.LO !== 32'd12 || bus.HI !== 32'd0) begin errors++; $display("FAIL flush_busy got n=%0d %h/%h want 5 00000000/0000000c", n, bus.HI, bus.LO); end
  endtask
  task automatic test_mflo_stall;
    int n = 0;
    int bad = 0;
    drive(4'd1, 32'd6, 32'd7);
    tick();
    drive(4'd8, 32'd0, 32'd0);
    #1;
    while (bus.E_MDU_busy === 1'b1 && n < 40) begin
      if (bus.E_MDU_stall !== 1'b1) bad++;
      n++;
      tick();
    end
    checks++; if (bad != 0 || n != 5) begin errors++; $display("FAIL mflo_stall got bad=%0d n=%0d want 0/5", bad, n); end
    checks++; if (bus.E_MDU_stall !== 1'b0 || bus.E_MDU_result !== 32'd42) begin errors++; $display("FAIL mflo_result got stall=%b %h want 0 0000002a", bus.E_MDU_stall, bus.E_MDU_result); end
  endtask
  task automatic test_back_to_back;
    int n;
    drive(4'd1, 32'd2, 32'd3);
    tick();
    drive(4'd1, 32'd4, 32'd5);
    #1;
    checks++; if (bus.E_MDU_stall !== 1'b1 || bus.E_MDU_busy !== 1'b1) begin errors++; $display("FAIL b2b_stall got stall=%b busy=%b want 1/1", bus.E_MDU_stall, bus.E_MDU_busy); end
    wait_done(n);
    checks++; if (n != 5 || bus.LO !== 32'd6 || bus.E_MDU_stall !== 1'b1) begin errors++; $display("FAIL b2b_first got n=%0d lo=%h stall=%b want 5 00000006 1", n, bus.LO, bus.E_MDU_stall); end
    tick();
    drive(4'd0, 32'd0, 32'd0);
    #1;
    checks++; if (bus.E_MDU_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%b want 1", bus.E_MDU_busy); end
    wait_done(n);
    checks++; if (bus.LO !== 32'd20) begin errors++; $display("FAIL b2b_second got %h want 00000014", bus.LO); end
  endtask
  task automatic test_reserved_op;
    drive(4'd12, 32'd1, 32'd1);
    #1;
    checks++; if (bus.E_MDU_stall !== 1'b0 || bus.E_MDU_result !== 32'd0) begin errors++; $display("FAIL op12_idle got stall=%b %h want 0 00000000", bus.E_MDU_stall, bus.E_MDU_result); end
    tick();
    checks++; if (bus.E_MDU_busy !== 1'b0 || bus.LO !== 32'd20) begin errors++; $display("FAIL op12_nostart got busy=%b lo=%h want 0 00000014", bus.E_MDU_busy, bus.LO); end
    drive(4'd0, 32'd0, 32'd0);
  endtask
  task automatic test_reset_mid_busy;
    drive(4'd1, 32'd6, 32'd7);
    tick();
    drive(4'd0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.E_MDU_busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin errors++; $display("FAIL rst_mid got busy=%b %h/%h want 0 0/0", bus.E_MDU_busy, bus.HI, bus.LO); end
    tick();
    reset = 1'b1;
    drive(4'd5, 32'hA5A5A5A5, 32'd0);
    tick();
    drive(4'd7, 32'd0, 32'd0);
    #1;
    checks++; if (bus.HI !== 32'hA5A5A5A5 || bus.E_MDU_result !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi got hi=%h res=%h want a5a5a5a5", bus.HI, bus.E_MDU_result); end
    checks++; if (bus.E_MDU_busy !== 1'b0 || bus.E_MDU_stall !== 1'b0) begin errors++; $display("FAIL post_rst_idle got busy=%b stall=%b want 0/0", bus.E_MDU_busy, bus.E_MDU_stall); end
    drive(4'd8, 32'd0, 32'd0);
    #1;
    checks++; if (bus.E_MDU_result !== 32'd0) begin errors++; $display("FAIL mflo_after_rst got %h want 0", bus.E_MDU_result); end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mflo_stall();
    test_back_to_back();
    test_reserved_op();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
